// File: rtl/branch_redirect_ctrl.sv
// EX-stage control-hazard controller: resolves branches/jumps against the
// front-end prediction, issues a registered redirect, and drains wrong-path slots.
module branch_redirect_ctrl #(
    parameter int XLEN         = 64,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             ex_cond_true,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pc_plus4,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             pipe_stall,
    output logic [1:0]       b_stall,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

    localparam logic [2:0]       DRAIN_LOAD = 3'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_reg, state_next;
    logic [2:0]        drain_reg, drain_next;
    logic [1:0]        b_stall_reg, b_stall_next;
    logic [XLEN-1:0]   redirect_pc_reg, redirect_pc_next;
    logic              flush_reg, flush_next;
    logic              busy_reg, busy_next;
    logic [CNT_W-1:0]  branch_cnt_reg, branch_cnt_next;
    logic [CNT_W-1:0]  mispred_cnt_reg, mispred_cnt_next;

    logic resolve;
    logic actual;
    logic mispredict;

    // Jump wins over branch when both flags are set.
    assign actual     = ex_is_jump | (ex_is_branch & ex_cond_true);
    assign resolve    = ex_valid & (ex_is_branch | ex_is_jump) & ~pipe_stall & (state_reg == IDLE);
    assign mispredict = resolve & (actual != ex_pred_taken);

    always_comb begin
        state_next       = state_reg;
        drain_next       = drain_reg;
        b_stall_next     = b_stall_reg;
        redirect_pc_next = redirect_pc_reg;
        flush_next       = flush_reg;
        busy_next        = busy_reg;
        branch_cnt_next  = branch_cnt_reg;
        mispred_cnt_next = mispred_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (resolve && !(&branch_cnt_reg))
                    branch_cnt_next = branch_cnt_reg + CNT_ONE;
                if (mispredict) begin
                    if (!(&mispred_cnt_reg))
                        mispred_cnt_next = mispred_cnt_reg + CNT_ONE;
                    b_stall_next     = actual ? 2'b01 : 2'b10;
                    redirect_pc_next = actual ? ex_target : ex_pc_plus4;
                    flush_next       = 1'b1;
                    busy_next        = 1'b1;
                    state_next       = REDIRECT;
                end
            end
            REDIRECT: begin
                // A stalled pipe has not consumed the redirect yet; hold everything.
                if (!pipe_stall) begin
                    b_stall_next = 2'b00;
                    flush_next   = 1'b0;
                    if (DRAIN_CYCLES > 0) begin
                        drain_next = DRAIN_LOAD;
                        state_next = DRAIN;
                    end else begin
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (!pipe_stall) begin
                    if (drain_reg <= 3'd1) begin
                        drain_next = 3'd0;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        drain_next = drain_reg - 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            drain_reg       <= 3'd0;
            b_stall_reg     <= 2'b00;
            redirect_pc_reg <= '0;
            flush_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            drain_reg       <= drain_next;
            b_stall_reg     <= b_stall_next;
            redirect_pc_reg <= redirect_pc_next;
            flush_reg       <= flush_next;
            busy_reg        <= busy_next;
            branch_cnt_reg  <= branch_cnt_next;
            mispred_cnt_reg <= mispred_cnt_next;
        end
    end

    assign b_stall     = b_stall_reg;
    assign redirect_pc = redirect_pc_reg;
    assign flush_if_id = flush_reg;
    assign flush_id_ex = flush_reg;
    assign busy        = busy_reg;
    assign branch_cnt  = branch_cnt_reg;
    assign mispred_cnt = mispred_cnt_reg;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vector table, saturation/reset
// sequences, and randomized traffic against a pending-redirect reference model.
module tb_branch_redirect_ctrl;
    localparam int XLEN  = 64;
    localparam int DRAIN = 1;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic ex_valid = 0, ex_is_branch = 0, ex_is_jump = 0, ex_cond_true = 0, ex_pred_taken = 0;
    logic [XLEN-1:0] ex_pc_plus4 = '0, ex_target = '0;
    logic pipe_stall = 0;

    logic [1:0]      b_stall,   s_b_stall;
    logic [XLEN-1:0] redirect_pc, s_redirect_pc;
    logic            flush_if_id, flush_id_ex, busy;
    logic            s_flush_if_id, s_flush_id_ex, s_busy;
    logic [31:0]     branch_cnt, mispred_cnt;
    logic [3:0]      s_branch_cnt, s_mispred_cnt;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(32), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .ex_cond_true(ex_cond_true), .ex_pred_taken(ex_pred_taken),
        .ex_pc_plus4(ex_pc_plus4), .ex_target(ex_target), .pipe_stall(pipe_stall),
        .b_stall(b_stall), .redirect_pc(redirect_pc), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .busy(busy), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt));

    // Narrow-counter instance sees identical stimulus, so saturation is exercised early.
    branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(4), .DRAIN_CYCLES(DRAIN)) dut_s (
        .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .ex_cond_true(ex_cond_true), .ex_pred_taken(ex_pred_taken),
        .ex_pc_plus4(ex_pc_plus4), .ex_target(ex_target), .pipe_stall(pipe_stall),
        .b_stall(s_b_stall), .redirect_pc(s_redirect_pc), .flush_if_id(s_flush_if_id),
        .flush_id_ex(s_flush_id_ex), .busy(s_busy), .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an optional pending redirect plus a count of drain slots left.
    bit              m_pend;
    int              m_code;
    logic [XLEN-1:0] m_pc;
    int              m_drain;
    longint          m_b, m_m;

    typedef struct {
        logic v, br, j, c, p;
        logic [XLEN-1:0] pc4, tgt;
        logic st;
        logic [1:0] e_bs;
        logic e_fl, e_busy;
        logic [XLEN-1:0] e_pc;
        int e_b, e_m;
    } vec_t;
    vec_t tbl[$];

    function automatic longint sat(longint c, int w);
        longint mx = (longint'(1) << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_code = 0; m_pc = '0; m_drain = 0; m_b = 0; m_m = 0;
    endtask

    task automatic model_clock();
        bit act;
        if (m_pend) begin
            if (!pipe_stall) begin
                m_pend  = 0;
                m_drain = DRAIN;
            end
        end else if (m_drain > 0) begin
            if (!pipe_stall) m_drain--;
        end else if (ex_valid && (ex_is_branch || ex_is_jump) && !pipe_stall) begin
            act = ex_is_jump || (ex_is_branch && ex_cond_true);
            m_b++;
            if (act != ex_pred_taken) begin
                m_m++;
                m_pend = 1;
                m_code = act ? 1 : 2;
                m_pc   = act ? ex_target : ex_pc_plus4;
            end
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, ".b_stall"},     64'(b_stall),     64'(m_pend ? m_code : 0));
        chk({tag, ".redirect_pc"}, redirect_pc,      m_pc);
        chk({tag, ".flush_if_id"}, 64'(flush_if_id), 64'(m_pend));
        chk({tag, ".flush_id_ex"}, 64'(flush_id_ex), 64'(m_pend));
        chk({tag, ".busy"},        64'(busy),        64'(m_pend || m_drain > 0));
        chk({tag, ".branch_cnt"},  64'(branch_cnt),  64'(sat(m_b, 32)));
        chk({tag, ".mispred_cnt"}, 64'(mispred_cnt), 64'(sat(m_m, 32)));
        chk({tag, ".s_b_stall"},   64'(s_b_stall),   64'(m_pend ? m_code : 0));
        chk({tag, ".s_branch_cnt"},  64'(s_branch_cnt),  64'(sat(m_b, 4)));
        chk({tag, ".s_mispred_cnt"}, 64'(s_mispred_cnt), 64'(sat(m_m, 4)));
    endtask

    task automatic set_in(logic v, logic br, logic j, logic c, logic p,
                          logic [XLEN-1:0] pc4, logic [XLEN-1:0] tgt, logic st);
        ex_valid = v; ex_is_branch = br; ex_is_jump = j; ex_cond_true = c;
        ex_pred_taken = p; ex_pc_plus4 = pc4; ex_target = tgt; pipe_stall = st;
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
    task automatic do_reset(string tag);
        #1 rstn = 1'b0;
        #1 model_reset();
        check_model({tag, ".rst"});
        $display("reset %s: b_stall=%0d busy=%0d cnt=%0d/%0d", tag, b_stall, busy, branch_cnt, mispred_cnt);
        #1 rstn = 1'b1;
    endtask

    task automatic add(logic v, logic br, logic j, logic c, logic p, logic [XLEN-1:0] pc4,
                       logic [XLEN-1:0] tgt, logic st, logic [1:0] ebs, logic efl, logic ebusy,
                       logic [XLEN-1:0] epc, int eb, int em);
        vec_t r;
        r.v = v; r.br = br; r.j = j; r.c = c; r.p = p; r.pc4 = pc4; r.tgt = tgt; r.st = st;
        r.e_bs = ebs; r.e_fl = efl; r.e_busy = ebusy; r.e_pc = epc; r.e_b = eb; r.e_m = em;
        tbl.push_back(r);
    endtask

    initial begin
        // Columns: v br j c p pc4 tgt stall | b_stall flush busy redirect_pc branch_cnt mispred_cnt
        add(1,1,0,1,0, 64'h80000004, 64'h80001000, 0,  2'd1,1,1, 64'h80001000, 1,1);
        add(0,0,0,0,0, 64'h0,        64'h0,        0,  2'd0,0,1, 64'h80001000, 1,1);
        add(0,0,0,0,0, 64'h0,        64'h0,        0,  2'd0,0,0, 64'h80001000, 1,1);
        add(1,1,0,0,1, 64'h80000104, 64'h80000500, 0,  2'd2,1,1, 64'h80000104, 2,2);
        add(0,0,0,0,0, 64'h0,        64'h0,        0,  2'd0,0,1, 64'h80000104, 2,2);
        add(0,0,0,0,0, 64'h0,        64'h0,        0,  2'd0,0,0, 64'h80000104, 2,2);
        add(1,1,0,1,0, 64'h10,       64'h1234,     0,  2'd1,1,1, 64'h1234,     3,3);
        add(1,1,0,1,0, 64'h20,       64'h2222,     1,  2'd1,1,1, 64'h1234,     3,3);
        add(1,1,0,1,0, 64'h20,       64'h2222,     1,  2'd1,1,1, 64'h1234,     3,3);
        add(1,1,0,1,0, 64'h20,       64'h2222,     1,  2'd1,1,1, 64'h1234,     3,3);
        add(0,0,0,0,0, 64'h0,        64'h0,        0,  2'd0,0,1, 64'h1234,     3,3);
        add(0,0,0,0,0, 64'h0,        64'h0,        0,  2'd0,0,0, 64'h1234,     3,3);
        add(1,1,0,1,1, 64'h30,       64'h3333,     0,  2'd0,0,0, 64'h1234,     4,3);
        add(1,0,1,0,0, 64'h40,       64'h2000,     0,  2'd1,1,1, 64'h2000,     5,4);
        add(1,1,0,1,0, 64'h50,       64'h5555,     0,  2'd0,0,1, 64'h2000,     5,4);
        add(1,1,0,1,0, 64'h60,       64'h6666,     0,  2'd0,0,0, 64'h2000,     5,4);
        add(1,1,0,0,1, 64'h80000200, 64'h7777,     1,  2'd0,0,0, 64'h2000,     5,4);
        add(1,1,0,0,1, 64'h80000200, 64'h7777,     0,  2'd2,1,1, 64'h80000200, 6,5);
        add(0,0,0,0,0, 64'h0,        64'h0,        0,  2'd0,0,1, 64'h80000200, 6,5);
        add(0,0,0,0,0, 64'h0,        64'h0,        1,  2'd0,0,1, 64'h80000200, 6,5);
        add(0,0,0,0,0, 64'h0,        64'h0,        0,  2'd0,0,0, 64'h80000200, 6,5);
        add(1,1,1,0,0, 64'h70,       64'h3000,     0,  2'd1,1,1, 64'h3000,     7,6);
        add(0,0,0,0,0, 64'h0,        64'h0,        0,  2'd0,0,1, 64'h3000,     7,6);
        add(0,0,0,0,0, 64'h0,        64'h0,        0,  2'd0,0,0, 64'h3000,     7,6);
        add(0,1,0,1,0, 64'h80,       64'h8888,     0,  2'd0,0,0, 64'h3000,     7,6);
        add(1,0,1,0,1, 64'h90,       64'h9999,     0,  2'd0,0,0, 64'h3000,     8,6);

        model_reset();
        do_reset("init");

        // Directed vector table.
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].v, tbl[i].br, tbl[i].j, tbl[i].c, tbl[i].p, tbl[i].pc4, tbl[i].tgt, tbl[i].st);
            step();
            chk($sformatf("vec%0d.b_stall", i),     64'(b_stall),     64'(tbl[i].e_bs));
            chk($sformatf("vec%0d.redirect_pc", i), redirect_pc,      tbl[i].e_pc);
            chk($sformatf("vec%0d.flush_if_id", i), 64'(flush_if_id), 64'(tbl[i].e_fl));
            chk($sformatf("vec%0d.flush_id_ex", i), 64'(flush_id_ex), 64'(tbl[i].e_fl));
            chk($sformatf("vec%0d.busy", i),        64'(busy),        64'(tbl[i].e_busy));
            chk($sformatf("vec%0d.branch_cnt", i),  64'(branch_cnt),  64'(tbl[i].e_b));
            chk($sformatf("vec%0d.mispred_cnt", i), 64'(mispred_cnt), 64'(tbl[i].e_m));
            $display("vec %0d: b_stall=%0d pc=0x%0h flush=%0d busy=%0d cnt=%0d/%0d",
                     i, b_stall, redirect_pc, flush_if_id, busy, branch_cnt, mispred_cnt);
        end

        // Saturation: 20 mispredicts pin the 4-bit counters at 15.
        do_reset("sat");
        for (int i = 0; i < 20; i++) begin
            set_in(1, 1, 0, 1, 0, 64'h100, 64'(32'h4000 + i * 4), 0);
            step();
            set_in(0, 0, 0, 0, 0, '0, '0, 0);
            step();
            step();
        end
        chk("sat.s_branch_cnt",  64'(s_branch_cnt),  64'd15);
        chk("sat.s_mispred_cnt", 64'(s_mispred_cnt), 64'd15);
        chk("sat.branch_cnt",    64'(branch_cnt),    64'd20);
        chk("sat.mispred_cnt",   64'(mispred_cnt),   64'd20);
        $display("sat: wide=%0d/%0d narrow=%0d/%0d", branch_cnt, mispred_cnt, s_branch_cnt, s_mispred_cnt);

        // Reset while REDIRECT is pending: nothing survives.
        set_in(1, 1, 0, 1, 0, 64'h100, 64'h5000, 0);
        step();
        check_model("midred.pre");
        set_in(0, 0, 0, 0, 0, '0, '0, 1);
        do_reset("midred");
        step();
        check_model("midred.post");
        $display("midred: b_stall=%0d busy=%0d", b_stall, busy);

        // Randomized traffic with occasional asynchronous reset pulses.
        do_reset("rnd");
        for (int i = 0; i < 1200; i++) begin
            set_in(($urandom_range(0, 9) < 7), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
            step();
            check_model($sformatf("rnd%0d", i));
            $display("rnd %0d: stall=%0d b_stall=%0d busy=%0d cnt=%0d/%0d",
                     i, pipe_stall, b_stall, busy, branch_cnt, mispred_cnt);
            if ($urandom_range(0, 149) == 0) do_reset($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
